// File: rtl/hci_mem_bank_responder.sv
// Single-bank TCDM responder: word array with byte-lane writes, optional LFSR-driven
// grant stalls, one-cycle registered response and saturating access statistics.
module hci_mem_bank_responder #(
   parameter int unsigned DW           = 32,
   parameter int unsigned BW           = 8,
   parameter int unsigned AW           = 12,
   parameter int unsigned STALL_EN     = 0,
   parameter int unsigned STALL_THRESH = 64,
   parameter int unsigned MAX_STALL    = 4,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   output logic             gnt_o,
   input  logic             wen_i,
   input  logic [AW-1:0]    add_i,
   input  logic [DW-1:0]    data_i,
   input  logic [DW/BW-1:0] be_i,
   output logic [DW-1:0]    r_data_o,
   output logic             r_valid_o,
   output logic [31:0]      stat_rd_o,
   output logic [31:0]      stat_wr_o,
   output logic [31:0]      stat_stall_o
);

   localparam int unsigned NB = DW / BW;

   logic [DW-1:0] mem [2**AW];

   logic [15:0]   lfsr_q;
   logic [31:0]   stall_cnt_q;
   logic          r_valid_q;
   logic [DW-1:0] r_data_q;
   logic [31:0]   stat_rd_q;
   logic [31:0]   stat_wr_q;
   logic [31:0]   stat_stall_q;

   logic lfsr_fb;
   logic stall;
   logic gnt_raw;

   always_comb begin
      lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
      stall   = (STALL_EN != 0) && (32'(lfsr_q[7:0]) < STALL_THRESH) &&
                (stall_cnt_q < MAX_STALL);
      gnt_raw = req_i & ~stall;
      // The visible grant is suppressed in reset, but the array write below still uses
      // gnt_raw so a write issued in the reset cycle is not lost.
      gnt_o   = gnt_raw & ~rst_i;
   end

   always_ff @(posedge clk_i) begin
      if (gnt_raw && !wen_i) begin
         for (int k = 0; k < NB; k++) begin
            if (be_i[k]) mem[add_i][k*BW +: BW] <= data_i[k*BW +: BW];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q       <= SEED;
         stall_cnt_q  <= '0;
         r_valid_q    <= 1'b0;
         r_data_q     <= '0;
         stat_rd_q    <= '0;
         stat_wr_q    <= '0;
         stat_stall_q <= '0;
      end else begin
         lfsr_q      <= {lfsr_q[14:0], lfsr_fb};
         stall_cnt_q <= (req_i && !gnt_o) ? stall_cnt_q + 32'd1 : 32'd0;
         r_valid_q   <= gnt_o;
         if (gnt_o) r_data_q <= wen_i ? mem[add_i] : '0;
         if (gnt_o && wen_i && (stat_rd_q != '1)) stat_rd_q <= stat_rd_q + 32'd1;
         if (gnt_o && !wen_i && (stat_wr_q != '1)) stat_wr_q <= stat_wr_q + 32'd1;
         if (req_i && !gnt_o && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 32'd1;
      end
   end

   assign r_valid_o    = r_valid_q;
   assign r_data_o     = r_data_q;
   assign stat_rd_o    = stat_rd_q;
   assign stat_wr_o    = stat_wr_q;
   assign stat_stall_o = stat_stall_q;

endmodule

// File: tb/tb_hci_mem_bank_responder.sv
// Directed bench for hci_mem_bank_responder: no-stall instance for data path and
// statistics, plus a worst-case stalling instance for the stall bound.
module tb_hci_mem_bank_responder;

   logic        clk = 1'b0;
   logic        rst, req, wen, gnt, r_valid;
   logic [11:0] add;
   logic [31:0] wdata, r_data, stat_rd, stat_wr, stat_stall;
   logic [3:0]  be;

   logic        rst2, req2, wen2, gnt2, r_valid2;
   logic [11:0] add2;
   logic [31:0] wdata2, r_data2, stat_rd2, stat_wr2, stat_stall2;
   logic [3:0]  be2;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_rd = 0;
   int exp_wr = 0;

   always #5 clk = ~clk;

   hci_mem_bank_responder dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .wen_i(wen), .add_i(add),
      .data_i(wdata), .be_i(be), .r_data_o(r_data), .r_valid_o(r_valid),
      .stat_rd_o(stat_rd), .stat_wr_o(stat_wr), .stat_stall_o(stat_stall)
   );

   hci_mem_bank_responder #(
      .STALL_EN(1), .STALL_THRESH(255), .MAX_STALL(4)
   ) dut_stall (
      .clk_i(clk), .rst_i(rst2), .req_i(req2), .gnt_o(gnt2), .wen_i(wen2), .add_i(add2),
      .data_i(wdata2), .be_i(be2), .r_data_o(r_data2), .r_valid_o(r_valid2),
      .stat_rd_o(stat_rd2), .stat_wr_o(stat_wr2), .stat_stall_o(stat_stall2)
   );

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; req = 1'b1; wen = 1'b1; add = '0; wdata = '0; be = 4'hF;
      #1;
      n_cmp++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got %b want 0", gnt); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      n_cmp++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", r_valid); end
      n_cmp++; if (r_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", r_data); end
      n_cmp++; if ({stat_rd, stat_wr, stat_stall} !== 96'h0) begin
         n_fail++; $display("FAIL reset_stats got %h %h %h want 0", stat_rd, stat_wr, stat_stall);
      end
      n_cmp++; if (dut.lfsr_q !== 16'hACE1) begin n_fail++; $display("FAIL reset_lfsr got %h want ace1", dut.lfsr_q); end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      req = 1'b1; wen = 1'b0; add = 12'd5; wdata = 32'hDEADBEEF; be = 4'hF;
      #1;
      n_cmp++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt got %b want 1", gnt); end
      exp_wr++;
      @(negedge clk);
      n_cmp++; if (r_valid !== 1'b1 || r_data !== 32'h0) begin
         n_fail++; $display("FAIL wr_resp got v=%b d=%h want v=1 d=0", r_valid, r_data);
      end
      wen = 1'b1;
      #1;
      n_cmp++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt got %b want 1", gnt); end
      exp_rd++;
      @(negedge clk);
      req = 1'b0;
      n_cmp++; if (r_valid !== 1'b1 || r_data !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL rd_resp got v=%b d=%h want v=1 d=deadbeef", r_valid, r_data);
      end
      n_cmp++; if (stat_wr !== 32'd1 || stat_rd !== 32'd1) begin
         n_fail++; $display("FAIL wr_rd_stats got wr=%0d rd=%0d want 1 1", stat_wr, stat_rd);
      end
      @(negedge clk);
      n_cmp++; if (r_valid !== 1'b0 || r_data !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL rd_hold got v=%b d=%h want v=0 d=deadbeef", r_valid, r_data);
      end
   endtask

   task automatic test_byte_enables();
      @(negedge clk);
      req = 1'b1; wen = 1'b0; add = 12'd7; wdata = 32'h11223344; be = 4'hF;
      @(negedge clk);
      wdata = 32'hAABBCCDD; be = 4'b0101;
      @(negedge clk);
      wen = 1'b1;
      exp_wr += 2; exp_rd++;
      @(negedge clk);
      req = 1'b0;
      n_cmp++; if (r_valid !== 1'b1 || r_data !== 32'h11BB33DD) begin
         n_fail++; $display("FAIL byte_en got v=%b d=%h want v=1 d=11bb33dd", r_valid, r_data);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         req = 1'b1; wen = 1'b0; add = 12'(i); wdata = 32'hC0DE0000 + 32'(i); be = 4'hF;
         exp_wr++;
      end
      for (int i = 0; i <= 16; i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_cmp++;
            if (r_valid !== 1'b1 || r_data !== 32'hC0DE0000 + 32'(i - 1)) begin
               n_fail++;
               $display("FAIL stream_%0d got v=%b d=%h want v=1 d=%h", i - 1, r_valid, r_data,
                        32'hC0DE0000 + 32'(i - 1));
            end
         end
         if (i < 16) begin
            req = 1'b1; wen = 1'b1; add = 12'(i);
            #1;
            n_cmp++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL stream_gnt_%0d got %b want 1", i, gnt); end
            exp_rd++;
         end else begin
            req = 1'b0;
         end
      end
      @(negedge clk);
      n_cmp++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end got %b want 0", r_valid); end
      n_cmp++; if (stat_rd !== 32'(exp_rd) || stat_wr !== 32'(exp_wr) || stat_stall !== 32'd0) begin
         n_fail++; $display("FAIL stream_stats got rd=%0d wr=%0d st=%0d want %0d %0d 0",
                            stat_rd, stat_wr, stat_stall, exp_rd, exp_wr);
      end
   endtask

   task automatic test_saturation();
      @(negedge clk);
      force dut.stat_rd_q = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.stat_rd_q;
      n_cmp++; if (stat_rd !== 32'hFFFF_FFFE) begin
         n_fail++; $display("FAIL sat_preload got %h want fffffffe", stat_rd);
      end
      req = 1'b1; wen = 1'b1; add = 12'd1;
      @(negedge clk);
      n_cmp++; if (stat_rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_first got %h want ffffffff", stat_rd); end
      @(negedge clk);
      @(negedge clk);
      req = 1'b0;
      n_cmp++; if (stat_rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_end got %h want ffffffff", stat_rd); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rst = 1'b1; req = 1'b1; wen = 1'b1; add = 12'd5;
      #1;
      n_cmp++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL rstmid_gnt got %b want 0", gnt); end
      @(negedge clk);
      n_cmp++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", r_valid); end
      wen = 1'b0; add = 12'd9; wdata = 32'h12345678; be = 4'hF;
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      n_cmp++; if ({stat_rd, stat_wr, stat_stall} !== 96'h0) begin
         n_fail++; $display("FAIL rstmid_stats got %h %h %h want 0", stat_rd, stat_wr, stat_stall);
      end
      n_cmp++; if (dut.lfsr_q !== 16'hACE1) begin n_fail++; $display("FAIL rstmid_lfsr got %h want ace1", dut.lfsr_q); end
      req = 1'b1; wen = 1'b1; add = 12'd9;
      @(negedge clk);
      req = 1'b0;
      n_cmp++; if (r_valid !== 1'b1 || r_data !== 32'h12345678) begin
         n_fail++; $display("FAIL rstmid_write got v=%b d=%h want v=1 d=12345678", r_valid, r_data);
      end
   endtask

   task automatic test_stall_bound();
      @(negedge clk);
      rst2 = 1'b1; req2 = 1'b0;
      @(negedge clk);
      rst2 = 1'b0; req2 = 1'b1; wen2 = 1'b1; add2 = 12'd3;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++;
         if (gnt2 !== (c == 4)) begin
            n_fail++; $display("FAIL stall_cycle_%0d got gnt=%b want %b", c, gnt2, (c == 4));
         end
         @(negedge clk);
      end
      req2 = 1'b0;
      n_cmp++; if (r_valid2 !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %b want 1", r_valid2); end
      n_cmp++; if (stat_stall2 !== 32'd4 || stat_rd2 !== 32'd1) begin
         n_fail++; $display("FAIL stall_stats got st=%0d rd=%0d want 4 1", stat_stall2, stat_rd2);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b1; req = 1'b0; wen = 1'b1; add = '0; wdata = '0; be = '0;
      rst2 = 1'b1; req2 = 1'b0; wen2 = 1'b1; add2 = '0; wdata2 = '0; be2 = 4'hF;
      test_reset();
      test_write_read();
      test_byte_enables();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      test_stall_bound();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
